// File: rtl/calc_pkg.sv
// Shared calculator definitions: key indices, keypad geometry and row-drive helpers.
package calc_pkg;

   localparam int unsigned KEY_W = 16;
   localparam int unsigned ROWS  = 4;
   localparam int unsigned COLS  = 4;

   localparam logic [ROWS-1:0] ROW_IDLE = 4'b1110;

   // Key index = row*4 + col on the 4x4 pad.
   localparam int unsigned KEY_1   = 0;
   localparam int unsigned KEY_2   = 1;
   localparam int unsigned KEY_3   = 2;
   localparam int unsigned KEY_ADD = 3;
   localparam int unsigned KEY_4   = 4;
   localparam int unsigned KEY_5   = 5;
   localparam int unsigned KEY_6   = 6;
   localparam int unsigned KEY_SUB = 7;
   localparam int unsigned KEY_7   = 8;
   localparam int unsigned KEY_8   = 9;
   localparam int unsigned KEY_9   = 10;
   localparam int unsigned KEY_MUL = 11;
   localparam int unsigned KEY_0   = 12;
   localparam int unsigned KEY_CLR = 13;
   localparam int unsigned KEY_EQ  = 14;
   localparam int unsigned KEY_DIV = 15;

   typedef logic [KEY_W-1:0] key_map_t;

   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2,
      ROW3 = 2'd3
   } row_state_e;

   // One-hot-low row drive pattern for a scan state.
   function automatic logic [ROWS-1:0] row_drive(input row_state_e s);
      return ~(4'(1) << s);
   endfunction

endpackage

// File: rtl/key_frame_debounce.sv
// Frame-level debounce: key_out follows a frame only after DEBOUNCE_FRAMES identical
// consecutive frames; key_pulse flags newly pressed keys for one clock.
module key_frame_debounce
   import calc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   input  key_map_t frame,
   input  logic     frame_done,
   output key_map_t key_out,
   output key_map_t key_pulse
);

   localparam int unsigned STB_W = $clog2(DEBOUNCE_FRAMES + 1);

   logic [STB_W-1:0] stable_q, stable_d;
   key_map_t         prev_q, prev_d;
   key_map_t         key_out_q, key_out_d;
   key_map_t         key_dly_q, key_dly_d;
   key_map_t         pulse_q, pulse_d;

   always_comb begin
      stable_d  = stable_q;
      prev_d    = prev_q;
      key_out_d = key_out_q;
      key_dly_d = key_out_q;
      pulse_d   = key_out_q & ~key_dly_q;

      if (frame_done) begin
         prev_d = frame;
         if (frame != prev_q) begin
            stable_d = '0;
         end else if (stable_q != STB_W'(DEBOUNCE_FRAMES)) begin
            stable_d = stable_q + STB_W'(1);
         end

         // Count includes the first frame, so commit when the count steps onto D-1.
         if (DEBOUNCE_FRAMES == 1) begin
            key_out_d = frame;
         end else if ((frame == prev_q) &&
                      ((32'(stable_q) + 32'd1) == 32'(DEBOUNCE_FRAMES - 1))) begin
            key_out_d = frame;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q  <= '0;
         prev_q    <= '0;
         key_out_q <= '0;
         key_dly_q <= '0;
         pulse_q   <= '0;
      end else begin
         stable_q  <= stable_d;
         prev_q    <= prev_d;
         key_out_q <= key_out_d;
         key_dly_q <= key_dly_d;
         pulse_q   <= pulse_d;
      end
   end

   assign key_out   = key_out_q;
   assign key_pulse = pulse_q;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: walks rows one-hot-low, samples synchronised active-low columns
// into a full-matrix frame and hands each completed frame to the debouncer.
module key_matrix_scan
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 60000,
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [COLS-1:0]  col,
   output logic [ROWS-1:0]  row,
   output logic [KEY_W-1:0] key_out,
   output logic [KEY_W-1:0] key_pulse
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   row_state_e       state_q, state_d;
   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [ROWS-1:0]  row_q, row_d;
   logic [COLS-1:0]  col_meta_q, col_sync_q;
   key_map_t         frame_q, frame_d;
   logic             frame_done_q, frame_done_d;
   logic             slot_end;

   // Two-flop synchroniser for the asynchronous column inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         col_meta_q <= col;
         col_sync_q <= col_meta_q;
      end
   end

   // Sampling on the last slot cycle leaves the synchroniser a full slot to settle.
   always_comb begin
      state_d      = state_q;
      slot_cnt_d   = slot_cnt_q + CNT_W'(1);
      frame_d      = frame_q;
      frame_done_d = 1'b0;
      slot_end     = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));

      if (slot_end) begin
         slot_cnt_d = '0;
         case (state_q)
            ROW0: begin
               frame_d[3:0]   = ~col_sync_q;
               state_d        = ROW1;
            end
            ROW1: begin
               frame_d[7:4]   = ~col_sync_q;
               state_d        = ROW2;
            end
            ROW2: begin
               frame_d[11:8]  = ~col_sync_q;
               state_d        = ROW3;
            end
            ROW3: begin
               frame_d[15:12] = ~col_sync_q;
               state_d        = ROW0;
               frame_done_d   = 1'b1;
            end
         endcase
      end

      row_d = row_drive(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ROW0;
         slot_cnt_q   <= '0;
         row_q        <= ROW_IDLE;
         frame_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_cnt_q   <= slot_cnt_d;
         row_q        <= row_d;
         frame_q      <= frame_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign row = row_q;

   key_frame_debounce #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame      (frame_q),
      .frame_done (frame_done_q),
      .key_out    (key_out),
      .key_pulse  (key_pulse)
   );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a keypad model drives columns from the DUT rows, expected
// key_out/key_pulse events are queued with the stimulus and matched as the DUT emits them.
module tb_key_matrix_scan;
   import calc_pkg::*;

   localparam int unsigned SD    = 8;
   localparam int unsigned DF    = 3;
   localparam int unsigned FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] key_out;
   logic [15:0] key_pulse;
   logic [15:0] pressed = 16'h0000;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] exp_out_q[$];
   logic [15:0] exp_pulse_q[$];

   always #5 clk = ~clk;

   // Keypad with pull-ups: a held key pulls its column low only while its row is driven.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row[r]) col = col & ~pressed[r*4 +: 4];
      end
   end

   key_matrix_scan #(
      .SCAN_DIV        (SD),
      .DEBOUNCE_FRAMES (DF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col       (col),
      .row       (row),
      .key_out   (key_out),
      .key_pulse (key_pulse)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: every key_out change and every non-zero pulse consumes a queued expectation.
   logic [15:0] last_out = 16'h0000;
   bit          out_changed = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_out    = 16'h0000;
         out_changed = 1'b0;
      end else begin
         if (key_pulse != 16'h0000) begin
            check_eq("pulse_follows_out", 32'(out_changed), 32'd1);
            if (exp_pulse_q.size() == 0) check_eq("pulse_unexpected", 32'(key_pulse), 32'd0);
            else check_eq("pulse_value", 32'(key_pulse), 32'(exp_pulse_q.pop_front()));
         end
         if (key_out != last_out) begin
            if (exp_out_q.size() == 0) check_eq("out_unexpected", 32'(key_out), 32'(last_out));
            else check_eq("out_value", 32'(key_out), 32'(exp_out_q.pop_front()));
            out_changed = 1'b1;
         end else begin
            out_changed = 1'b0;
         end
         last_out = key_out;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic drive_keys(input logic [15:0] keys, input bit exp_change, input bit exp_pulse);
      @(posedge clk);
      #2;
      pressed = keys;
      if (exp_change) exp_out_q.push_back(keys);
      if (exp_pulse) exp_pulse_q.push_back(keys);
   endtask

   task automatic check_drained(input string tag);
      check_eq({tag, "_outq"}, 32'(exp_out_q.size()), 32'd0);
      check_eq({tag, "_pulseq"}, 32'(exp_pulse_q.size()), 32'd0);
   endtask

   initial begin
      // Reset with no keys, then check the row walk from release.
      cycles(3);
      #1;
      check_eq("rst_row", 32'(row), 32'h0000000E);
      check_eq("rst_out", 32'(key_out), 32'd0);
      check_eq("rst_pulse", 32'(key_pulse), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      check_eq("row_k0", 32'(row), 32'h0000000E);
      cycles(7);  #1; check_eq("row_k7",  32'(row), 32'h0000000E);
      cycles(1);  #1; check_eq("row_k8",  32'(row), 32'h0000000D);
      cycles(23); #1; check_eq("row_k31", 32'(row), 32'h00000007);
      cycles(1);  #1; check_eq("row_k32", 32'(row), 32'h0000000E);
      cycles(9 * FRAME);
      #1;
      check_eq("idle_out", 32'(key_out), 32'd0);

      // Press and hold '5'.
      drive_keys(16'h0020, 1'b1, 1'b1);
      cycles((DF + 1) * FRAME + 4 + 2);
      #1;
      check_eq("press5_out", 32'(key_out), 32'h0020);
      check_drained("press5");
      cycles(20 * FRAME);
      #1;
      check_eq("hold5_out", 32'(key_out), 32'h0020);

      // Release '5': key_out clears, no pulse.
      drive_keys(16'h0000, 1'b1, 1'b0);
      cycles(5 * FRAME);
      #1;
      check_eq("rel5_out", 32'(key_out), 32'd0);
      check_drained("rel5");

      // Bounce '=' frame by frame, then hold it.
      for (int i = 0; i < 8; i++) begin
         drive_keys((i % 2 == 0) ? 16'h4000 : 16'h0000, 1'b0, 1'b0);
         cycles(FRAME - 1);
      end
      #1;
      check_eq("bounce_out", 32'(key_out), 32'd0);
      drive_keys(16'h4000, 1'b1, 1'b1);
      cycles(60);
      #1;
      check_eq("eq_early_out", 32'(key_out), 32'd0);
      cycles(5 * FRAME - 60);
      #1;
      check_eq("eq_out", 32'(key_out), 32'h4000);
      check_drained("eq");

      drive_keys(16'h0000, 1'b1, 1'b0);
      cycles(5 * FRAME);
      #1;
      check_eq("releq_out", 32'(key_out), 32'd0);

      // '1' and '+' together pulse in the same cycle.
      drive_keys(16'h0009, 1'b1, 1'b1);
      cycles(5 * FRAME);
      #1;
      check_eq("dual_out", 32'(key_out), 32'h0009);
      check_drained("dual");

      drive_keys(16'h0000, 1'b1, 1'b0);
      cycles(5 * FRAME);
      #1;
      check_drained("reldual");

      // Press '9', reset mid-debounce, keep holding.
      drive_keys(16'h0400, 1'b0, 1'b0);
      cycles(48);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst9_row", 32'(row), 32'h0000000E);
      check_eq("rst9_out", 32'(key_out), 32'd0);
      check_eq("rst9_pulse", 32'(key_pulse), 32'd0);
      cycles(5);
      #2;
      rst_n = 1'b1;
      exp_out_q.push_back(16'h0400);
      exp_pulse_q.push_back(16'h0400);
      #1;
      check_eq("rel9_row", 32'(row), 32'h0000000E);
      cycles(3 * FRAME);
      #1;
      check_eq("k96_out", 32'(key_out), 32'd0);
      check_eq("k96_pulse", 32'(key_pulse), 32'd0);
      cycles(1); #1;
      check_eq("k97_out", 32'(key_out), 32'h0400);
      check_eq("k97_pulse", 32'(key_pulse), 32'd0);
      cycles(1); #1;
      check_eq("k98_pulse", 32'(key_pulse), 32'h0400);
      cycles(1); #1;
      check_eq("k99_pulse", 32'(key_pulse), 32'd0);
      cycles(4 * FRAME);
      #1;
      check_eq("hold9_out", 32'(key_out), 32'h0400);
      check_drained("end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
